// File: rtl/optimsoc_pkg.sv
// Shared NoC definitions: flit layout and link-arbiter state encoding.
// Used by the link arbiter and the NoC routers.
package optimsoc_pkg;

  localparam int FLIT_WIDTH       = 34;
  localparam int FLIT_LAST_BIT    = 33;
  localparam int FLIT_PAYLOAD_MSB = 31;
  localparam int FLIT_PAYLOAD_LSB = 0;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/noc_rr_select.sv
// Round-robin one-hot selector: the first set request after ptr wins, with
// wrap-around from N-1 to 0. Purely combinational.
module noc_rr_select #(
  parameter  int N  = 2,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  always_comb begin
    grant = '0;
    for (int i = 1; i <= N; i++) begin
      if (grant == '0 && req[(int'(ptr) + i) % N]) begin
        grant[(int'(ptr) + i) % N] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc_vc_link_arbiter.sv
// Zero-latency arbiter multiplexing CHANNELS virtual channels onto one
// physical link, with optional packet locking and a per-VC length check.
module noc_vc_link_arbiter #(
  parameter int FLIT_WIDTH  = optimsoc_pkg::FLIT_WIDTH,
  parameter int CHANNELS    = 2,
  parameter int PACKET_LOCK = 1,
  parameter int MAX_PKT_LEN = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [CHANNELS-1:0][FLIT_WIDTH-1:0] in_flit,
  input  logic [CHANNELS-1:0]                 in_valid,
  output logic [CHANNELS-1:0]                 in_ready,
  output logic [FLIT_WIDTH-1:0]               out_flit,
  output logic [CHANNELS-1:0]                 out_valid,
  input  logic [CHANNELS-1:0]                 out_ready,
  output logic                                err_pkt_len
);
  import optimsoc_pkg::*;

  // Handshake: a flit moves on VC v in the cycle where out_valid[v] and
  // out_ready[v] are both high; in_ready mirrors that same transfer.
  localparam int PTR_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CNT_W = $clog2(MAX_PKT_LEN + 1);
  localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(CHANNELS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PKT_LEN);
  localparam logic [CNT_W-1:0] CNT_ERR = CNT_W'(MAX_PKT_LEN - 1);

  arb_state_e          state_q, state_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]    lock_vc_q, lock_vc_d;
  logic [CNT_W-1:0]    cnt_q [CHANNELS];
  logic [CNT_W-1:0]    cnt_d [CHANNELS];
  logic [CHANNELS-1:0] eligible, rr_grant, grant;
  logic [PTR_W-1:0]    g;
  logic                xfer, last_flit;

  assign eligible = in_valid & out_ready;

  noc_rr_select #(.N(CHANNELS)) u_rr_select (
    .req   (eligible),
    .ptr   (rr_ptr_q),
    .grant (rr_grant)
  );

  // While locked only the owning VC may move, even if others are eligible.
  always_comb begin
    grant = '0;
    if (!rst) begin
      if (PACKET_LOCK != 0 && state_q == ARB_LOCKED) begin
        if (eligible[lock_vc_q]) grant[lock_vc_q] = 1'b1;
      end else begin
        grant = rr_grant;
      end
    end
  end

  always_comb begin
    g = '0;
    for (int v = 0; v < CHANNELS; v++) begin
      if (grant[v]) g = PTR_W'(v);
    end
  end

  assign out_flit    = in_flit[g];
  assign out_valid   = grant;
  assign in_ready    = grant & out_ready;
  assign xfer        = |(grant & out_ready);
  assign last_flit   = out_flit[FLIT_LAST_BIT];
  assign err_pkt_len = xfer && !last_flit && (cnt_q[g] == CNT_ERR);

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    lock_vc_d = lock_vc_q;
    for (int v = 0; v < CHANNELS; v++) cnt_d[v] = cnt_q[v];
    if (xfer) begin
      rr_ptr_d = g;
      if (PACKET_LOCK != 0) begin
        case (state_q)
          ARB_IDLE: begin
            if (!last_flit) begin
              state_d   = ARB_LOCKED;
              lock_vc_d = g;
            end
          end
          ARB_LOCKED: begin
            if (last_flit) state_d = ARB_IDLE;
          end
          default: state_d = ARB_IDLE;
        endcase
      end
      for (int v = 0; v < CHANNELS; v++) begin
        if (g == PTR_W'(v)) begin
          if (last_flit)               cnt_d[v] = '0;
          else if (cnt_q[v] != CNT_MAX) cnt_d[v] = cnt_q[v] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ARB_IDLE;
      rr_ptr_q  <= PTR_RST;
      lock_vc_q <= '0;
      for (int v = 0; v < CHANNELS; v++) cnt_q[v] <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      lock_vc_q <= lock_vc_d;
      for (int v = 0; v < CHANNELS; v++) cnt_q[v] <= cnt_d[v];
    end
  end

endmodule

// File: doc/noc_vc_link_arbiter.md
NOC_VC_LINK_ARBITER -- requirements
Module: noc_vc_link_arbiter

Interface
REQ-001 Parameter FLIT_WIDTH, default 34: flit width, with last-flit flag at bit 33 and payload at bits 31:0.
REQ-002 Parameter CHANNELS, default 2: number of virtual channels sharing the physical link; legal range 1..8.
REQ-003 Parameter PACKET_LOCK, default 1: 1 keeps a grant until that VC's last flit; 0 arbitrates per flit.
REQ-004 Parameter MAX_PKT_LEN, default 8: maximum legal flits per packet, including the last flit.
REQ-005 clk  input  1  single clock; all state is updated on the rising edge.
REQ-006 rst  input  1  reset, asynchronous and active-high.
REQ-007 in_flit  input  CHANNELS x FLIT_WIDTH  per-VC flit from the upstream VC buffers.
REQ-008 in_valid  input  CHANNELS  per-VC flit valid.
REQ-009 in_ready  output  CHANNELS  per-VC accept; at most one bit is high per cycle.
REQ-010 out_flit  output  FLIT_WIDTH  shared physical-link flit.
REQ-011 out_valid  output  CHANNELS  one-hot or zero; identifies the VC of out_flit.
REQ-012 out_ready  input  CHANNELS  per-VC downstream credit/ready.
REQ-013 err_pkt_len  output  1  one-cycle pulse when a packet exceeds MAX_PKT_LEN flits.

Function
REQ-014 A VC is eligible when in_valid[v] and out_ready[v] are both high; a transfer on VC v occurs when out_valid[v] and out_ready[v] are both high.
REQ-015 Datapath is combinational: out_flit = in_flit[g], out_valid = onehot(g) when a grant g exists, and in_ready = out_valid & out_ready.
REQ-016 Zero latency: the input and output handshakes happen in the same cycle; no flit storage.
REQ-017 Arbitration is round-robin: search starts at rr_ptr+1 mod CHANNELS; rr_ptr loads g on every transfer; wrap-around from CHANNELS-1 to 0.
REQ-018 FSM states are IDLE and LOCKED; the FSM is only active when PACKET_LOCK=1.
REQ-019 IDLE: the grant is the round-robin winner; a transfer with last=0 moves to LOCKED with lock_vc=g; a transfer with last=1 stays in IDLE.
REQ-020 LOCKED: only lock_vc may be granted, regardless of other eligible VCs; a transfer with last=1 returns to IDLE; with out_ready[lock_vc]=0 or in_valid[lock_vc]=0, out_valid=0 and the state is held.
REQ-021 PACKET_LOCK=0: arbitrate every cycle, with no FSM effect; per-VC packet tracking still applies for the length check.
REQ-022 Per-VC flit counter, width clog2(MAX_PKT_LEN+1): increments on each transfer on its VC and clears on a transfer with last=1.
REQ-023 A transfer with last=0 when the counter equals MAX_PKT_LEN-1 pulses err_pkt_len for one cycle; the counter saturates at MAX_PKT_LEN and the flit is still forwarded.
REQ-024 No eligible VC: out_valid=0, in_ready=0, and the pointer and FSM are unchanged.
REQ-025 A single-flit packet (last=1 on the first flit) never enters LOCKED.
REQ-026 With CHANNELS=1 the block degenerates to a pass-through gated by the FSM; rr_ptr is constant 0.

Reset
REQ-027 rst asynchronously forces: FSM=IDLE, rr_ptr=CHANNELS-1 (so VC0 wins first), lock_vc=0, all flit counters=0, err_pkt_len=0.
REQ-028 While rst is high, out_valid=0 and in_ready=0 regardless of the inputs.
REQ-029 Reset mid-packet abandons the lock; after release, arbitration restarts at VC0 with no error pulse.

Structure
REQ-030 The flit-layout constants (FLIT_WIDTH=34, last-flag bit 33, payload 31:0) and the arbiter state enum belong in the shared optimsoc package.
REQ-031 The round-robin search is a separate sub-module, noc_rr_select (inputs: request vector, pointer; output: one-hot grant), reusable by the NoC routers.

Verification
REQ-032 CHANNELS=2, PACKET_LOCK=1: VC0 sends a 3-flit packet while VC1 is valid throughout -> grants VC0,VC0,VC0 then VC1; VC1 is never granted mid-packet.
REQ-033 PACKET_LOCK=0: both VCs continuously valid with single-flit packets -> grants alternate 0,1,0,1 starting at VC0 after reset.
REQ-034 LOCKED on VC1, out_ready[1]=0 for 5 cycles while VC0 is valid -> out_valid=0 for those 5 cycles; VC1 resumes when ready returns.
REQ-035 MAX_PKT_LEN=4: a 5-flit packet on VC0 -> err_pkt_len pulses exactly once, in the cycle of the 4th transfer; all 5 flits are forwarded intact.
REQ-036 Assert rst after flit 2 of a 4-flit VC1 packet -> outputs are 0 immediately; after release, with both VCs valid, VC0 is granted first and err_pkt_len stays 0.
REQ-037 Random stimulus, all cycles -> out_valid is one-hot or zero, in_ready equals out_valid & out_ready, and the per-VC flit order is preserved.
